// File: rtl/turn_controller.sv
// Per-turn sequencer for the two-player fight datapath: latches moves, issues one
// resolve strobe per turn, scores rounds from hp and declares the match winner.
module turn_controller #(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int ROUNDS_TO_WIN  = 2,
    parameter int TW             = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       punch1,
    input  logic       kick1,
    input  logic       wait1,
    input  logic       jump1,
    input  logic       left1,
    input  logic       right1,
    input  logic       punch2,
    input  logic       kick2,
    input  logic       wait2,
    input  logic       jump2,
    input  logic       left2,
    input  logic       right2,
    input  logic [1:0] hp1,
    input  logic [1:0] hp2,
    output logic [2:0] move1,
    output logic [2:0] move2,
    output logic       resolve,
    output logic       dp_reset,
    output logic [2:0] phase,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic [1:0] winner,
    output logic       game_over
);

    // Datapath handshake: resolve is a one-cycle strobe with no back-pressure;
    // move1/move2 are valid while resolve is high and hold until the next commit.
    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_COLLECT = 3'd1,
        S_RESOLVE = 3'd2,
        S_SETTLE  = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    WIN_TARGET = 2'(ROUNDS_TO_WIN);

    state_t        state;
    logic          c1, c2;
    logic [TW-1:0] timer;
    logic          resolve_q;
    logic          p1_any, p2_any;
    logic [2:0]    enc1, enc2;

    function automatic logic [2:0] encode(input logic punch, input logic kick,
                                          input logic jump, input logic left,
                                          input logic right);
        logic [2:0] code;
        code = 3'd0;
        if (punch)      code = 3'd1;
        else if (kick)  code = 3'd2;
        else if (jump)  code = 3'd3;
        else if (left)  code = 3'd4;
        else if (right) code = 3'd5;
        return code;
    endfunction

    assign p1_any = punch1 | kick1 | wait1 | jump1 | left1 | right1;
    assign p2_any = punch2 | kick2 | wait2 | jump2 | left2 | right2;
    assign enc1   = encode(punch1, kick1, jump1, left1, right1);
    assign enc2   = encode(punch2, kick2, jump2, left2, right2);

    assign phase   = state;
    assign resolve = resolve_q & en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            c1        <= 1'b0;
            c2        <= 1'b0;
            timer     <= '0;
            resolve_q <= 1'b0;
            move1     <= 3'd0;
            move2     <= 3'd0;
            dp_reset  <= 1'b0;
            wins1     <= 2'd0;
            wins2     <= 2'd0;
            winner    <= 2'b00;
            game_over <= 1'b0;
        end else if (en) begin
            resolve_q <= 1'b0;
            case (state)
                S_INIT: begin
                    c1       <= 1'b0;
                    c2       <= 1'b0;
                    timer    <= '0;
                    dp_reset <= 1'b1;
                    state    <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (!c1 && p1_any) begin
                        c1    <= 1'b1;
                        move1 <= enc1;
                    end
                    if (!c2 && p2_any) begin
                        c2    <= 1'b1;
                        move2 <= enc2;
                    end
                    if ((c1 | p1_any) && (c2 | p2_any)) begin
                        state     <= S_RESOLVE;
                        resolve_q <= 1'b1;
                    end else if (c1 ^ c2) begin
                        // One side committed: count down to defaulting the other to wait.
                        if (timer == TIMER_LAST) begin
                            state     <= S_RESOLVE;
                            resolve_q <= 1'b1;
                            if (!c1) move1 <= 3'd0;
                            if (!c2) move2 <= 3'd0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else if (p1_any || p2_any) begin
                        timer <= '0;
                    end
                end
                S_RESOLVE: begin
                    c1    <= 1'b0;
                    c2    <= 1'b0;
                    timer <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (hp1 != 2'd0 && hp2 != 2'd0) begin
                        state <= S_COLLECT;
                    end else if (hp1 != 2'd0) begin
                        if (wins1 != WIN_TARGET) wins1 <= wins1 + 2'd1;
                        if (wins1 + 2'd1 == WIN_TARGET) begin
                            winner    <= 2'b01;
                            game_over <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            dp_reset <= 1'b0;
                            state    <= S_INIT;
                        end
                    end else if (hp2 != 2'd0) begin
                        if (wins2 != WIN_TARGET) wins2 <= wins2 + 2'd1;
                        if (wins2 + 2'd1 == WIN_TARGET) begin
                            winner    <= 2'b10;
                            game_over <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            dp_reset <= 1'b0;
                            state    <= S_INIT;
                        end
                    end else begin
                        dp_reset <= 1'b0;
                        state    <= S_INIT;
                    end
                end
                S_OVER: begin
                    state <= S_OVER;
                end
                default: begin
                    dp_reset <= 1'b0;
                    state    <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Directed and randomized checks of turn_controller against a turn-level model.
module tb_turn_controller;

    localparam int T   = 8;
    localparam int RTW = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [5:0] p1, p2;   // {right, left, jump, wait, kick, punch}
    logic [1:0] hp1, hp2;
    logic [2:0] move1, move2, phase;
    logic       resolve, dp_reset, game_over;
    logic [1:0] wins1, wins2, winner;

    int checks = 0;
    int fails  = 0;

    localparam logic [5:0] PUNCH = 6'b000001;
    localparam logic [5:0] KICK  = 6'b000010;
    localparam logic [5:0] JUMP  = 6'b001000;
    localparam logic [5:0] LEFT  = 6'b010000;
    localparam logic [5:0] RIGHT = 6'b100000;

    turn_controller #(.TIMEOUT_CYCLES(T), .ROUNDS_TO_WIN(RTW), .TW(4)) dut (
        .clk(clk), .reset(reset), .en(en),
        .punch1(p1[0]), .kick1(p1[1]), .wait1(p1[2]), .jump1(p1[3]), .left1(p1[4]), .right1(p1[5]),
        .punch2(p2[0]), .kick2(p2[1]), .wait2(p2[2]), .jump2(p2[3]), .left2(p2[4]), .right2(p2[5]),
        .hp1(hp1), .hp2(hp2), .move1(move1), .move2(move2), .resolve(resolve),
        .dp_reset(dp_reset), .phase(phase), .wins1(wins1), .wins2(wins2),
        .winner(winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Move code chosen by priority punch > kick > jump > left > right > wait.
    function automatic int enc(input logic [5:0] v);
        if (v[0]) return 1;
        if (v[1]) return 2;
        if (v[3]) return 3;
        if (v[4]) return 4;
        if (v[5]) return 5;
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press2(input logic [5:0] a, input logic [5:0] b);
        p1 = a;
        p2 = b;
        step();
        p1 = 6'd0;
        p2 = 6'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"}, int'(phase), 0);
        check({tag, "_dp_reset"}, int'(dp_reset), 0);
        check({tag, "_resolve"}, int'(resolve), 0);
        check({tag, "_move1"}, int'(move1), 0);
        check({tag, "_move2"}, int'(move2), 0);
        check({tag, "_wins1"}, int'(wins1), 0);
        check({tag, "_wins2"}, int'(wins2), 0);
        check({tag, "_winner"}, int'(winner), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
    endtask

    task automatic restart();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("restart_phase", int'(phase), 1);
    endtask

    initial begin
        int exp_w1, exp_w2, exp_phase, first, mode, d, m1, m2;
        int h1, h2;
        logic [5:0] va, vb, junk;

        reset = 1'b0;
        en    = 1'b1;
        p1    = 6'd0;
        p2    = 6'd0;
        hp1   = 2'd3;
        hp2   = 2'd3;
        step();
        step();
        check_reset_outputs("in_reset");

        // Release: one INIT cycle with dp_reset low, then COLLECT.
        reset = 1'b1;
        check("rel_phase0", int'(phase), 0);
        check("rel_dp0", int'(dp_reset), 0);
        step();
        check("rel_phase1", int'(phase), 1);
        check("rel_dp1", int'(dp_reset), 1);
        check("rel_resolve", int'(resolve), 0);

        // Simultaneous commit.
        press2(PUNCH, JUMP);
        check("sim_resolve", int'(resolve), 1);
        check("sim_move1", int'(move1), 1);
        check("sim_move2", int'(move2), 3);
        step();
        check("sim_settle", int'(phase), 3);
        check("sim_resolve_off", int'(resolve), 0);
        step();
        check("sim_collect", int'(phase), 1);

        // Priority within one cycle, repeat press ignored, staggered second commit.
        press2(PUNCH | KICK, 6'd0);
        check("pri_noresolve", int'(resolve), 0);
        check("pri_move1", int'(move1), 1);
        press2(KICK, 6'd0);
        check("rep_move1", int'(move1), 1);
        check("rep_noresolve", int'(resolve), 0);
        press2(6'd0, LEFT);
        check("stag_resolve", int'(resolve), 1);
        check("stag_move1", int'(move1), 1);
        check("stag_move2", int'(move2), 4);
        step();
        check("stag_single_pulse", int'(resolve), 0);
        step();
        check("stag_collect", int'(phase), 1);

        // Timeout: P1 alone, P2 defaults to wait after T cycles.
        press2(RIGHT, 6'd0);
        for (int k = 1; k < T; k++) begin
            step();
            check("to_wait", int'(resolve), 0);
        end
        step();
        check("to_resolve", int'(resolve), 1);
        check("to_move1", int'(move1), 5);
        check("to_move2", int'(move2), 0);
        step();
        step();
        check("to_collect", int'(phase), 1);

        // Timeout stretched by three disabled cycles.
        press2(6'd0, KICK);
        for (int k = 0; k < 3; k++) begin
            step();
            check("en_pre", int'(resolve), 0);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("en_frozen_resolve", int'(resolve), 0);
            check("en_frozen_phase", int'(phase), 1);
        end
        en = 1'b1;
        for (int k = 0; k < T - 4; k++) begin
            step();
            check("en_post", int'(resolve), 0);
        end
        step();
        check("en_resolve", int'(resolve), 1);
        check("en_move1", int'(move1), 0);
        check("en_move2", int'(move2), 2);
        step();
        step();

        // P1 wins two rounds.
        press2(PUNCH, PUNCH);
        step();
        hp2 = 2'd0;
        step();
        check("w1a_phase", int'(phase), 0);
        check("w1a_dp", int'(dp_reset), 0);
        check("w1a_wins1", int'(wins1), 1);
        check("w1a_go", int'(game_over), 0);
        hp2 = 2'd3;
        step();
        check("w1a_collect", int'(phase), 1);
        check("w1a_dp1", int'(dp_reset), 1);
        press2(PUNCH, PUNCH);
        step();
        hp2 = 2'd0;
        step();
        check("w1b_phase", int'(phase), 4);
        check("w1b_wins1", int'(wins1), 2);
        check("w1b_winner", int'(winner), 1);
        check("w1b_go", int'(game_over), 1);
        hp2 = 2'd3;
        press2(PUNCH, KICK);
        check("over_noresolve", int'(resolve), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("over_hold", int'(phase), 4);
            check("over_resolve", int'(resolve), 0);
        end

        // Reset leaves OVER immediately.
        reset = 1'b0;
        #1;
        check_reset_outputs("over_reset");
        step();
        reset = 1'b1;
        step();
        check("post_reset_collect", int'(phase), 1);

        // Draw.
        press2(KICK, KICK);
        step();
        hp1 = 2'd0;
        hp2 = 2'd0;
        step();
        check("draw_phase", int'(phase), 0);
        check("draw_wins1", int'(wins1), 0);
        check("draw_wins2", int'(wins2), 0);
        hp1 = 2'd3;
        hp2 = 2'd3;
        step();

        // P2 takes a round, then reset mid-SETTLE clears it.
        press2(JUMP, PUNCH);
        step();
        hp1 = 2'd0;
        step();
        check("w2_wins2", int'(wins2), 1);
        check("w2_phase", int'(phase), 0);
        hp1 = 2'd3;
        step();
        press2(LEFT, RIGHT);
        check("mid_move1", int'(move1), 4);
        check("mid_move2", int'(move2), 5);
        step();
        check("mid_settle", int'(phase), 3);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_settle_reset");
        step();
        reset = 1'b1;
        step();

        // Randomized turns against the turn-level model.
        exp_w1 = 0;
        exp_w2 = 0;
        for (int turn = 0; turn < 60; turn++) begin
            mode  = $urandom_range(0, 2);
            first = $urandom_range(0, 1);
            va    = 6'($urandom_range(1, 63));
            vb    = 6'($urandom_range(1, 63));
            if (mode == 0) begin
                press2(va, vb);
                m1 = enc(va);
                m2 = enc(vb);
            end else begin
                if (first == 0) press2(va, 6'd0);
                else press2(6'd0, va);
                check("rnd_first_noresolve", int'(resolve), 0);
                d = (mode == 1) ? $urandom_range(1, T - 1) : T;
                for (int k = 1; k < d; k++) begin
                    junk = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'd0;
                    if (first == 0) press2(junk, 6'd0);
                    else press2(6'd0, junk);
                    check("rnd_gap_noresolve", int'(resolve), 0);
                end
                if (mode == 1) begin
                    if (first == 0) press2(6'd0, vb);
                    else press2(vb, 6'd0);
                    m1 = (first == 0) ? enc(va) : enc(vb);
                    m2 = (first == 0) ? enc(vb) : enc(va);
                end else begin
                    step();
                    m1 = (first == 0) ? enc(va) : 0;
                    m2 = (first == 0) ? 0 : enc(va);
                end
            end
            check("rnd_resolve", int'(resolve), 1);
            check("rnd_move1", int'(move1), m1);
            check("rnd_move2", int'(move2), m2);
            step();
            check("rnd_settle", int'(phase), 3);
            check("rnd_resolve_off", int'(resolve), 0);
            h1  = $urandom_range(0, 3);
            h2  = $urandom_range(0, 3);
            hp1 = 2'(h1);
            hp2 = 2'(h2);
            step();
            hp1 = 2'd3;
            hp2 = 2'd3;
            if (h1 != 0 && h2 != 0) begin
                exp_phase = 1;
            end else if (h2 == 0 && h1 != 0) begin
                exp_w1++;
                exp_phase = (exp_w1 == RTW) ? 4 : 0;
            end else if (h1 == 0 && h2 != 0) begin
                exp_w2++;
                exp_phase = (exp_w2 == RTW) ? 4 : 0;
            end else begin
                exp_phase = 0;
            end
            check("rnd_phase", int'(phase), exp_phase);
            check("rnd_wins1", int'(wins1), exp_w1);
            check("rnd_wins2", int'(wins2), exp_w2);
            check("rnd_game_over", int'(game_over), (exp_phase == 4) ? 1 : 0);
            check("rnd_winner", int'(winner),
                  (exp_phase != 4) ? 0 : ((exp_w1 == RTW) ? 1 : 2));
            if (exp_phase == 0) begin
                check("rnd_dp_low", int'(dp_reset), 0);
                step();
                check("rnd_reenter", int'(phase), 1);
            end else if (exp_phase == 4) begin
                restart();
                exp_w1 = 0;
                exp_w2 = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Sequences the two-player fight datapath (`Logic`) on a per-turn basis.
- Latches each player's one-cycle move pulse and waits until both players have committed or a timeout expires.
- Then issues a single resolve strobe with encoded moves, and evaluates hp after the datapath settles.
- Tracks rounds won and declares the match winner; owns the datapath's round reset.

Parameters:
- TIMEOUT_CYCLES, 8, cycles after the first commit before the uncommitted player defaults to wait (>=2).
- ROUNDS_TO_WIN, 2, rounds a player must win to end the match (1..3).
- TW, 4, timer width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 freezes all state
- punch1, kick1, wait1, jump1, left1, right1  in  1 each  player 1 move pulses
- punch2, kick2, wait2, jump2, left2, right2  in  1 each  player 2 move pulses
- hp1  in  2  player 1 hp from datapath
- hp2  in  2  player 2 hp from datapath
- move1  out  3  encoded player 1 move: 0 wait, 1 punch, 2 kick, 3 jump, 4 left, 5 right
- move2  out  3  encoded player 2 move, same encoding
- resolve  out  1  one-cycle strobe: datapath applies move1/move2
- dp_reset  out  1  active-low round reset to datapath
- phase  out  3  0 INIT, 1 COLLECT, 2 RESOLVE, 3 SETTLE, 4 OVER
- wins1  out  2  rounds won by player 1
- wins2  out  2  rounds won by player 2
- winner  out  2  00 none, 01 P1, 10 P2
- game_over  out  1  match finished

Behaviour:
- Reset (reset=0, asynchronous):
  - phase=INIT, dp_reset=0, resolve=0, move1=move2=0.
  - wins1=wins2=0, winner=0, game_over=0.
  - Commit flags c1=c2=0, timer=0.
- en=0: every register holds, resolve forced 0, move inputs ignored. Async reset still acts.
- dp_reset=0 exactly while phase=INIT; otherwise 1.
- INIT: lasts one cycle (en=1). Clears c1, c2 and timer, then goes to COLLECT.
- COLLECT, commit:
  - p_any = OR of a player's six inputs.
  - When cN=0 and p_any=1, set cN=1 and latch moveN by priority punch > kick > jump > left > right > wait.
  - Presses while cN=1 are ignored.
- COLLECT, advance:
  - Next state is RESOLVE at the same edge on which (c1|p1_any)&(c2|p2_any) becomes true.
  - Simultaneous presses therefore give resolve=1 in the cycle immediately after the press edge.
- COLLECT, timer:
  - Timer loads 0 at the first commit edge and increments each enabled cycle while exactly one player is committed.
  - When timer==TIMEOUT_CYCLES-1 with the other player still uncommitted: next state is RESOLVE, and the missing move is forced to 0 (wait).
  - Result: resolve is high TIMEOUT_CYCLES cycles after the first commit edge.
  - With neither player committed, the timer does not run; COLLECT waits indefinitely.
- RESOLVE: resolve=1 for exactly one cycle; c1 and c2 cleared; then SETTLE. Presses ignored.
- move1/move2 hold their values from commit through RESOLVE and SETTLE until the next commit overwrites them.
- SETTLE: one cycle. hp1/hp2 are sampled at its closing edge:
  - Both nonzero: go to COLLECT.
  - hp2==0, hp1!=0: wins1++.
  - hp1==0, hp2!=0: wins2++.
  - Both 0: draw, no increment.
  - After a round end: if the incremented count equals ROUNDS_TO_WIN, set winner and game_over=1 and go to OVER; otherwise go to INIT.
- Win counters never exceed ROUNDS_TO_WIN (saturating).
- OVER: terminal. resolve stays 0, inputs ignored; only reset leaves it.
- Reset mid-turn: latched moves and commits are discarded immediately, and wins are cleared.

Test Plan:
- Reset release → phase goes 0 for one clk with dp_reset=0, then phase=1 with dp_reset=1; all other outputs 0.
- punch1 and jump2 pulsed in the same COLLECT cycle → next cycle resolve=1, move1=1, move2=3. Then phase=3 for one cycle, then back to 1 (hp1=hp2=3).
- punch1 and kick1 in the same cycle, then kick1 alone, then left2 → move1=1, move2=4; exactly one resolve pulse.
- right1 only, TIMEOUT_CYCLES=8 → resolve=1 eight cycles after the commit edge, with move1=5, move2=0. Hold en=0 for 3 cycles mid-wait → resolve delayed by exactly 3 cycles.
- hp2=0 during SETTLE:
  - First time → wins1=1 and INIT with a 1-cycle dp_reset=0.
  - Repeat → wins1=2, winner=01, game_over=1, phase=4; further presses give no resolve.
- hp1=hp2=0 during SETTLE → wins unchanged, phase goes to INIT. reset=0 asserted mid-SETTLE → outputs immediately at reset values.
